// File: rtl/mcpu_hs.sv
// Multi-cycle MIPS-subset core with one req/ack memory port, a 32x32 register file and an illegal-instruction halt.
// Define MCPU_PERF_EN to add the perf_cycles / perf_instret counter outputs.
`timescale 1ns/1ps
module mcpu_hs #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [31:0]       dbg_pc
`ifdef MCPU_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0]       alu_q, alu_d, mdr_q, mdr_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       addr_full;
    logic [31:0]       rf_q [32];
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic [25:0]       target26;
    logic [31:0]       imm_sext, imm_zext, br_off, rs_val, rt_val;
    logic signed [31:0] a_s, b_s;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign target26 = ir_q[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};
    assign br_off   = {{14{imm[15]}}, imm, 2'b00};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign a_s      = a_q;
    assign b_s      = b_q;

    function automatic logic is_legal(input logic [5:0] opc, input logic [5:0] fn);
        case (opc)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu_rtype(input logic [5:0] fn,
                                              input logic signed [31:0] x,
                                              input logic signed [31:0] y);
        case (fn)
            FN_ADD:  return x + y;
            FN_SUB:  return x - y;
            FN_SLT:  return {31'd0, (x < y)};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;

        case (state_q)
            S_FETCH: begin
                if (mem_req_q && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + br_off;
                if (!is_legal(op, funct)) begin
                    state_d = S_HALT;
                end else if (op == OP_J || op == OP_JAL) begin
                    // pc_q already holds the address of the following instruction (link value)
                    pc_d    = {pc_q[31:28], target26, 2'b00};
                    state_d = S_FETCH;
                    if (op == OP_JAL) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d    = a_q;
                            state_d = S_FETCH;
                        end else begin
                            alu_d   = alu_rtype(funct, a_s, b_s);
                            state_d = S_WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + imm_sext;
                        state_d = S_WB;
                    end
                    OP_XORI: begin
                        alu_d   = a_q ^ imm_zext;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_sext;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) ^ (op == OP_BNE)) pc_d = alu_q;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_req_q && mem_ack) begin
                    if (op == OP_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we = 1'b1;
                if (op == OP_RTYPE) begin
                    rf_waddr = rd;
                    rf_wdata = alu_q;
                end else if (op == OP_LW) begin
                    rf_waddr = rt;
                    rf_wdata = mdr_q;
                end else begin
                    rf_waddr = rt;
                    rf_wdata = alu_q;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase

        // Port outputs are registered from the next state so they hold steady for a whole request
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && (op == OP_SW);
        addr_full   = (state_d == S_MEM) ? alu_d : pc_d;
        mem_addr_d  = addr_full[ADDR_W-1:0];
        mem_wdata_d = b_d;
        halted_d    = (state_d == S_HALT);
    end

`ifdef MCPU_PERF_EN
    logic [31:0] cycles_q, cycles_d, instret_q, instret_d;
    logic        retire;

    always_comb begin
        retire    = (state_q != S_FETCH) && (state_q != S_HALT) && (state_d == S_FETCH);
        cycles_d  = halted_q ? cycles_q : cycles_q + 32'd1;
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q  <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_instret = instret_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            alu_q       <= 32'd0;
            mdr_q       <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            halted_q    <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign dbg_pc    = pc_q;

endmodule

// File: tb/tb_mcpu_hs.sv
// Directed bench for mcpu_hs: programs run from a word memory model with configurable ack delay.
`timescale 1ns/1ps
module tb_mcpu_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, dbg_pc;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
`ifdef MCPU_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    always #5 clk = ~clk;

    mcpu_hs #(.ADDR_W(32), .RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .dbg_pc(dbg_pc)
`ifdef MCPU_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          stab_err = 0;
    logic        pending = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    logic [31:0] mem [0:255];
    int          fetch_cyc [0:255];
    logic [31:0] fetch_q [$];
    logic [31:0] st_addr_q [$];
    logic [31:0] st_data_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] a26);
        return {op, a26};
    endfunction

    localparam logic [31:0] ILL = 32'hFC00_0000;

    always @(posedge clk) cyc++;

    // Memory model: acks after lat wait cycles, logs fetches/stores, flags request changes mid-wait
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (pending && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
                stab_err++;
            if (wcnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    st_addr_q.push_back(mem_addr);
                    st_data_q.push_back(mem_wdata);
                end else begin
                    fetch_cyc[mem_addr[9:2]] = cyc;
                    fetch_q.push_back(mem_addr);
                end
                wcnt    = 0;
                pending = 1'b0;
            end else begin
                wcnt++;
                pending = 1'b1;
                p_addr  = mem_addr;
                p_we    = mem_we;
                p_wdata = mem_wdata;
            end
        end else begin
            wcnt    = 0;
            pending = 1'b0;
        end
    end

    task automatic begin_test(input int l);
        @(negedge clk);
        reset = 1'b1;
        lat   = l;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 32'hDEAD_BEEF;
            fetch_cyc[i] = 0;
        end
        fetch_q.delete();
        st_addr_q.delete();
        st_data_q.delete();
        stab_err = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_seq [9];
        int n;

        // Reset state, first fetch address, and all registers reading zero
        begin_test(0);
        mem[32'h40 >> 2] = i_op(6'h2B, 5'd0, 5'd5,  16'h0200);
        mem[32'h44 >> 2] = i_op(6'h2B, 5'd0, 5'd31, 16'h0204);
        mem[32'h48 >> 2] = i_op(6'h2B, 5'd0, 5'd17, 16'h0208);
        mem[32'h4C >> 2] = ILL;
        repeat (2) @(negedge clk);
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check_val("rst_halted",  {31'd0, halted},  32'd0);
        check_val("rst_dbg_pc",  dbg_pc, 32'h40);
        reset = 1'b0;
        @(negedge clk);
        check_val("a_first_req",  {31'd0, mem_req}, 32'd1);
        check_val("a_first_addr", mem_addr, 32'h40);
        @(negedge clk);
        check_val("a_pc_after_ack", dbg_pc, 32'h44);
        wait_halt("a_halt", 200);
        check_val("a_r5_zero",  mem[32'h200 >> 2], 32'd0);
        check_val("a_r31_zero", mem[32'h204 >> 2], 32'd0);
        check_val("a_r17_zero", mem[32'h208 >> 2], 32'd0);
        check_val("a_halt_pc",  dbg_pc, 32'h50);
        repeat (4) @(negedge clk);
        check_val("a_halt_req",  {31'd0, mem_req}, 32'd0);
        check_val("a_halt_hold", {31'd0, halted},  32'd1);

        // ALU program at zero wait states
        begin_test(0);
        mem[32'h40 >> 2] = i_op(6'h08, 5'd0, 5'd1, 16'd5);
        mem[32'h44 >> 2] = i_op(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[32'h48 >> 2] = r_op(5'd1, 5'd2, 5'd3, 6'h20);
        mem[32'h4C >> 2] = r_op(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[32'h50 >> 2] = r_op(5'd2, 5'd1, 5'd5, 6'h22);
        mem[32'h54 >> 2] = r_op(5'd1, 5'd2, 5'd8, 6'h2A);
        mem[32'h58 >> 2] = i_op(6'h0E, 5'd2, 5'd7, 16'hFFFF);
        mem[32'h5C >> 2] = i_op(6'h2B, 5'd0, 5'd3, 16'h0200);
        mem[32'h60 >> 2] = i_op(6'h2B, 5'd0, 5'd4, 16'h0204);
        mem[32'h64 >> 2] = i_op(6'h2B, 5'd0, 5'd5, 16'h0208);
        mem[32'h68 >> 2] = i_op(6'h2B, 5'd0, 5'd8, 16'h020C);
        mem[32'h6C >> 2] = i_op(6'h2B, 5'd0, 5'd7, 16'h0210);
        mem[32'h70 >> 2] = ILL;
        release_reset();
        wait_halt("b_halt", 300);
        check_val("b_add",   mem[32'h200 >> 2], 32'd2);
        check_val("b_slt1",  mem[32'h204 >> 2], 32'd1);
        check_val("b_sub",   mem[32'h208 >> 2], 32'hFFFF_FFF8);
        check_val("b_slt0",  mem[32'h20C >> 2], 32'd0);
        check_val("b_xori",  mem[32'h210 >> 2], 32'hFFFF_0002);
        check_val("b_add_lat",  32'(fetch_cyc[32'h4C >> 2] - fetch_cyc[32'h48 >> 2]), 32'd4);
        check_val("b_addi_lat", 32'(fetch_cyc[32'h44 >> 2] - fetch_cyc[32'h40 >> 2]), 32'd4);
        check_val("b_sw_lat",   32'(fetch_cyc[32'h60 >> 2] - fetch_cyc[32'h5C >> 2]), 32'd4);
`ifdef MCPU_PERF_EN
        check_val("b_instret", perf_instret, 32'd12);
        check_val("b_cycles",  perf_cycles,  32'd51);
`endif

        // Store then load with three wait cycles per request
        begin_test(3);
        mem[32'h40 >> 2] = i_op(6'h08, 5'd0, 5'd1, 16'd5);
        mem[32'h44 >> 2] = i_op(6'h2B, 5'd0, 5'd1, 16'd8);
        mem[32'h48 >> 2] = i_op(6'h23, 5'd0, 5'd6, 16'd8);
        mem[32'h4C >> 2] = i_op(6'h2B, 5'd0, 5'd6, 16'h0200);
        mem[32'h50 >> 2] = ILL;
        release_reset();
        wait_halt("c_halt", 400);
        check_val("c_st_addr", (st_addr_q.size() > 0) ? st_addr_q[0] : 32'hFFFF_FFFF, 32'd8);
        check_val("c_st_data", (st_data_q.size() > 0) ? st_data_q[0] : 32'hFFFF_FFFF, 32'd5);
        check_val("c_mem8",    mem[2], 32'd5);
        check_val("c_lw_r6",   mem[32'h200 >> 2], 32'd5);
        check_val("c_stable",  32'(stab_err), 32'd0);
        check_val("c_lw_lat",  32'(fetch_cyc[32'h4C >> 2] - fetch_cyc[32'h48 >> 2]), 32'd11);

        // Branches, JAL/JR and J
        begin_test(0);
        mem[32'h40 >> 2] = i_op(6'h04, 5'd0, 5'd0, 16'd2);
        mem[32'h44 >> 2] = i_op(6'h08, 5'd0, 5'd9, 16'd1);
        mem[32'h48 >> 2] = i_op(6'h08, 5'd0, 5'd9, 16'd2);
        mem[32'h4C >> 2] = i_op(6'h05, 5'd0, 5'd0, 16'd5);
        mem[32'h50 >> 2] = j_op(6'h03, 26'h20);
        mem[32'h54 >> 2] = i_op(6'h2B, 5'd0, 5'd31, 16'h0200);
        mem[32'h58 >> 2] = i_op(6'h2B, 5'd0, 5'd9,  16'h0204);
        mem[32'h5C >> 2] = j_op(6'h02, 26'h30);
        mem[32'h80 >> 2] = i_op(6'h08, 5'd0, 5'd10, 16'd7);
        mem[32'h84 >> 2] = r_op(5'd31, 5'd0, 5'd0, 6'h08);
        mem[32'hC0 >> 2] = ILL;
        release_reset();
        wait_halt("d_halt", 300);
        exp_seq = '{32'h40, 32'h4C, 32'h50, 32'h80, 32'h84, 32'h54, 32'h58, 32'h5C, 32'hC0};
        check_val("d_fetch_count", 32'(fetch_q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            check_val($sformatf("d_fetch%0d", i),
                      (i < fetch_q.size()) ? fetch_q[i] : 32'hFFFF_FFFF, exp_seq[i]);
        check_val("d_r31",     mem[32'h200 >> 2], 32'h54);
        check_val("d_r9",      mem[32'h204 >> 2], 32'd0);
        check_val("d_beq_lat", 32'(fetch_cyc[32'h4C >> 2] - fetch_cyc[32'h40 >> 2]), 32'd3);
        check_val("d_jal_lat", 32'(fetch_cyc[32'h80 >> 2] - fetch_cyc[32'h50 >> 2]), 32'd2);
        check_val("d_jr_lat",  32'(fetch_cyc[32'h54 >> 2] - fetch_cyc[32'h84 >> 2]), 32'd3);
        check_val("d_j_lat",   32'(fetch_cyc[32'hC0 >> 2] - fetch_cyc[32'h5C >> 2]), 32'd2);

        // Reset while a load is waiting for its ack
        begin_test(10);
        mem[32'h40 >> 2] = i_op(6'h23, 5'd0, 5'd1, 16'h0200);
        release_reset();
        n = 0;
        while (!(mem_req && mem_addr == 32'h200) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("e_mem_addr", mem_addr, 32'h200);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("e_req_dropped", {31'd0, mem_req}, 32'd0);
        check_val("e_pc_reset",    dbg_pc, 32'h40);
        lat   = 0;
        reset = 1'b0;
        @(negedge clk);
        check_val("e_refetch_req",  {31'd0, mem_req}, 32'd1);
        check_val("e_refetch_addr", mem_addr, 32'h40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcpu_hs.md
Name: mcpu_hs

Overview:
- Next-generation multi-cycle MIPS-subset CPU core for the JAS project.
- Compared with the fixed-timing core, it adds:
  - a single variable-latency memory port with a req/ack handshake;
  - a parametrised reset vector and address width;
  - an integrated 32x32 register file;
  - an illegal-instruction halt.
- Sits between the testbench/top and a shared instruction+data memory model.

Parameters:
- ADDR_W, 32: width of mem_addr; the low ADDR_W bits of the 32-bit byte address are driven.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  memory request; held high until accepted.
- mem_we  output  1  1 = store, 0 = load/fetch; valid while mem_req.
- mem_addr  output  ADDR_W  byte address; valid while mem_req.
- mem_wdata  output  32  store data; valid while mem_req && mem_we.
- mem_rdata  input  32  read data; sampled in the cycle mem_ack=1.
- mem_ack  input  1  completes the request in the same cycle; ignored when mem_req=0.
- halted  output  1  core stopped on an illegal instruction.
- dbg_pc  output  32  current PC (address of the next fetch).

Behaviour:
- Reset: on a clk edge with reset=1:
  - state<=FETCH, PC<=RESET_PC, IR/A/B/ALUOut<=0;
  - all 32 registers <=0;
  - mem_req=0, mem_we=0, halted=0.
- Reset mid-transaction abandons the request; mem_req is low the cycle after reset.
- Register file: $0 reads 0 and ignores writes. Two combinational read ports, one write port on the clk edge.
- Supported ISA, MIPS encodings:
  - R-type (op 0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2A (signed), JR 0x08;
  - ADDI 0x08 (sign-extended imm);
  - XORI 0x0E (zero-extended imm);
  - LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
- Arithmetic: ADD/SUB/ADDI wrap modulo 2^32; no overflow trap.
- Memory addresses: no alignment check; effective address bits pass through unchanged.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stay while mem_ack=0. On ack: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2) (branch target). Then:
    - J → PC<={PC[31:28],addr26,2'b00}, go to FETCH;
    - JAL → same PC update, plus rf[31]<=PC (already PC+4), go to FETCH;
    - illegal op/funct → HALT;
    - otherwise → EXEC.
  - EXEC:
    - R-type ALU → ALUOut<=A op B, go to WB;
    - JR → PC<=A, go to FETCH;
    - ADDI/XORI → ALUOut<=A op imm, go to WB;
    - LW/SW → ALUOut<=A+sext(imm), go to MEM;
    - BEQ/BNE → if (A==B) XOR bne then PC<=ALUOut; go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(SW), mem_wdata=B. Stay until ack.
    - LW: MDR<=mem_rdata, go to WB.
    - SW: go to FETCH.
  - WB:
    - R-type → rf[rd]<=ALUOut;
    - ADDI/XORI → rf[rt]<=ALUOut;
    - LW → rf[rt]<=MDR.
    - Then go to FETCH.
  - HALT: halted=1, mem_req=0. Absorbing until reset.
- Latency with ack in the first request cycle:
  - J/JAL: 2 cycles;
  - BEQ/BNE/JR: 3;
  - ALU/SW: 4;
  - LW: 5.
  - Each extra wait cycle on ack adds 1.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable from the first cycle of mem_req until its ack.
  - mem_req may stay high into the next request (FETCH after MEM) with a new address only after the ack cycle.

Optional Feature:
- MCPU_PERF_EN defined: adds output ports perf_cycles[31:0] and perf_instret[31:0].
  - Both are 0 on reset.
  - perf_cycles increments every non-reset cycle while halted=0.
  - perf_instret increments on each instruction completion: the transition into FETCH from DECODE, EXEC, MEM or WB.
  - Both wrap at 2^32.
- Undefined: ports absent; no counters.

Test Plan:
- Reset with RESET_PC=32'h40, 0-wait memory → first mem_addr=0x40; dbg_pc=0x44 after the first ack; all registers read 0.
- Program ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2; SLT $4,$2,$1; SUB $5,$2,$1 → $3=2, $4=1, $5=0xFFFFFFF8; the ADD takes 4 cycles.
- SW $1,8($0) then LW $6,8($0), with memory ack delayed 3 cycles per request → mem_addr/mem_wdata (8/5) stable through the waits; $6=5; LW takes 5+3*2 cycles.
- BEQ taken with imm=2 at PC 0x10 → next fetch 0x1C; BNE not taken → 0x14; JAL at 0x20 to addr26=0x10 → fetch 0x40, $31=0x24; JR $31 → fetch 0x24.
- Illegal opcode 0x3F fetched → halted=1 after DECODE; mem_req stays 0. Reset asserted mid-MEM-wait → mem_req low next cycle, fetch restarts at RESET_PC.
- With MCPU_PERF_EN: run the 5-instruction ALU program → perf_instret=5, perf_cycles=20 at 0 wait states.
